mem_arbiter: RTL and testbench

//  Arbitrates the single shared main-memory port between the I-cache (miss refill) and the
//  D-cache (miss refill / dirty-line write-back). One transaction is outstanding at a time.

---
 rtl/brisc_pkg.sv | 19 +
 rtl/arb_picker.sv | 31 +++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/brisc_pkg.sv
// Shared types and default widths for the main-memory arbiter.
package brisc_pkg;

  localparam int ARB_ADDR_BITS = 32;
  localparam int ARB_LINE_BITS = 128;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_e;

  typedef enum logic {
    OWNER_IC,
    OWNER_DC
  } arb_owner_e;

endpackage

// File: rtl/arb_picker.sv
// Combinational grant select between I-cache and D-cache requests.
// MEM_ARB_ROUND_ROBIN_EN selects alternating grants on contention; otherwise D-cache wins.
module arb_picker
  import brisc_pkg::*;
(
  input  logic       ic_req,
  input  logic       dc_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  arb_owner_e last_owner,
`endif
  output logic       grant_valid,
  output arb_owner_e grant_owner
);

  always_comb begin
    grant_valid = ic_req | dc_req;
    grant_owner = OWNER_IC;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (ic_req && dc_req) begin
      grant_owner = (last_owner == OWNER_DC) ? OWNER_IC : OWNER_DC;
    end else if (dc_req) begin
      grant_owner = OWNER_DC;
    end
`else
    if (dc_req) begin
      grant_owner = OWNER_DC;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shared main-memory port arbiter for I-cache refills and D-cache refills/write-backs.
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate grants on contention instead of D-over-I priority.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   ARB_IDLE  | no transaction; arbitrate and latch winner's request
//   ARB_ISSUE | mem_req_out high for this single cycle
//   ARB_WAIT  | address/data held, waiting for mem_resp_in
//   ARB_RESP  | owner's fill pulse with its line on data_out
module mem_arbiter
  import brisc_pkg::*;
#(
  parameter int ADDR_BITS = ARB_ADDR_BITS,
  parameter int LINE_BITS = ARB_LINE_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ic_req_in,
  input  logic [ADDR_BITS-1:0] ic_addr_in,
  output logic                 ic_fill_out,
  output logic [LINE_BITS-1:0] ic_data_out,
  input  logic                 dc_req_in,
  input  logic                 dc_write_in,
  input  logic [ADDR_BITS-1:0] dc_addr_in,
  input  logic [LINE_BITS-1:0] dc_wdata_in,
  output logic                 dc_fill_out,
  output logic [LINE_BITS-1:0] dc_data_out,
  output logic                 mem_req_out,
  output logic                 mem_write_out,
  output logic [ADDR_BITS-1:0] mem_addr_out,
  output logic [LINE_BITS-1:0] mem_wdata_out,
  input  logic                 mem_resp_in,
  input  logic [LINE_BITS-1:0] mem_rdata_in,
  output logic                 busy_out
);

  arb_state_e state;
  arb_owner_e owner;
  logic       grant_valid;
  arb_owner_e grant_owner;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_owner_e last_owner;
`endif

  arb_picker u_picker (
    .ic_req      (ic_req_in),
    .dc_req      (dc_req_in),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .last_owner  (last_owner),
`endif
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ARB_IDLE;
      owner         <= OWNER_IC;
      ic_fill_out   <= 1'b0;
      ic_data_out   <= '0;
      dc_fill_out   <= 1'b0;
      dc_data_out   <= '0;
      mem_req_out   <= 1'b0;
      mem_write_out <= 1'b0;
      mem_addr_out  <= '0;
      mem_wdata_out <= '0;
      busy_out      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      // Pretend D-cache went last so the I-cache wins the first contention.
      last_owner    <= OWNER_DC;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_valid) begin
            owner       <= grant_owner;
            state       <= ARB_ISSUE;
            mem_req_out <= 1'b1;
            busy_out    <= 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_owner  <= grant_owner;
`endif
            if (grant_owner == OWNER_DC) begin
              mem_write_out <= dc_write_in;
              mem_addr_out  <= dc_addr_in;
              mem_wdata_out <= dc_write_in ? dc_wdata_in : '0;
            end else begin
              mem_write_out <= 1'b0;
              mem_addr_out  <= ic_addr_in;
              mem_wdata_out <= '0;
            end
          end
        end
        ARB_ISSUE: begin
          mem_req_out <= 1'b0;
          state       <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (mem_resp_in) begin
            state <= ARB_RESP;
            if (owner == OWNER_IC) begin
              ic_fill_out <= 1'b1;
              ic_data_out <= mem_rdata_in;
            end else begin
              dc_fill_out <= 1'b1;
              dc_data_out <= mem_write_out ? '0 : mem_rdata_in;
            end
          end
        end
        ARB_RESP: begin
          ic_fill_out <= 1'b0;
          ic_data_out <= '0;
          dc_fill_out <= 1'b0;
          dc_data_out <= '0;
          busy_out    <= 1'b0;
          state       <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; expectations switch on MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         ic_req_in;
  logic [31:0]  ic_addr_in;
  logic         ic_fill_out;
  logic [127:0] ic_data_out;
  logic         dc_req_in;
  logic         dc_write_in;
  logic [31:0]  dc_addr_in;
  logic [127:0] dc_wdata_in;
  logic         dc_fill_out;
  logic [127:0] dc_data_out;
  logic         mem_req_out;
  logic         mem_write_out;
  logic [31:0]  mem_addr_out;
  logic [127:0] mem_wdata_out;
  logic         mem_resp_in;
  logic [127:0] mem_rdata_in;
  logic         busy_out;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [127:0] LINE_AA = {4{32'hAAAA_AAAA}};
  localparam logic [127:0] LINE_55 = {4{32'h5555_5555}};
  localparam logic [127:0] LINE_C3 = {4{32'hC3C3_C3C3}};
  localparam logic [127:0] LINE_17 = {4{32'h1717_1717}};

  mem_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .ic_req_in     (ic_req_in),
    .ic_addr_in    (ic_addr_in),
    .ic_fill_out   (ic_fill_out),
    .ic_data_out   (ic_data_out),
    .dc_req_in     (dc_req_in),
    .dc_write_in   (dc_write_in),
    .dc_addr_in    (dc_addr_in),
    .dc_wdata_in   (dc_wdata_in),
    .dc_fill_out   (dc_fill_out),
    .dc_data_out   (dc_data_out),
    .mem_req_out   (mem_req_out),
    .mem_write_out (mem_write_out),
    .mem_addr_out  (mem_addr_out),
    .mem_wdata_out (mem_wdata_out),
    .mem_resp_in   (mem_resp_in),
    .mem_rdata_in  (mem_rdata_in),
    .busy_out      (busy_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy_out, 1'b0);
    chk({tag, "_memreq"}, mem_req_out, 1'b0);
    chk({tag, "_fills"}, {ic_fill_out, dc_fill_out}, 2'b00);
    chk({tag, "_data"}, ic_data_out | dc_data_out, '0);
  endtask

  // Waits (bounded) for the issue pulse, checks the transaction, answers after
  // wait_cycles extra WAIT cycles and checks the owner's fill. Returns at the
  // negedge inside the fill cycle.
  task automatic serve(input string tag, input bit exp_dc, input logic [31:0] exp_addr,
                       input bit exp_write, input logic [127:0] exp_wdata,
                       input logic [127:0] rdata, input int wait_cycles, output int issue_lat);
    int n = 0;
    do begin
      tick();
      n++;
    end while (mem_req_out !== 1'b1 && n < 12);
    issue_lat = n;
    chk({tag, "_issue"}, mem_req_out, 1'b1);
    chk({tag, "_addr"}, mem_addr_out, exp_addr);
    chk({tag, "_write"}, mem_write_out, exp_write);
    chk({tag, "_wdata"}, mem_wdata_out, exp_wdata);
    chk({tag, "_nofill_issue"}, {ic_fill_out, dc_fill_out}, 2'b00);
    if (exp_dc && exp_write) dc_wdata_in = '0;
    tick();
    chk({tag, "_req_one_cycle"}, mem_req_out, 1'b0);
    for (int i = 0; i < wait_cycles; i++) begin
      chk({tag, "_wait_nofill"}, {ic_fill_out, dc_fill_out}, 2'b00);
      chk({tag, "_wait_wdata"}, mem_wdata_out, exp_wdata);
      tick();
    end
    chk({tag, "_wait_busy"}, busy_out, 1'b1);
    chk({tag, "_wait_addr"}, mem_addr_out, exp_addr);
    mem_resp_in  = 1'b1;
    mem_rdata_in = rdata;
    tick();
    mem_resp_in  = 1'b0;
    mem_rdata_in = '0;
    chk({tag, "_fills"}, {ic_fill_out, dc_fill_out}, exp_dc ? 2'b01 : 2'b10);
    chk({tag, "_ic_data"}, ic_data_out, exp_dc ? 128'h0 : rdata);
    chk({tag, "_dc_data"}, dc_data_out, (exp_dc && !exp_write) ? rdata : 128'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int lat;
    bit first_dc;
    reset        = 1'b1;
    ic_req_in    = 1'b0;
    ic_addr_in   = '0;
    dc_req_in    = 1'b0;
    dc_write_in  = 1'b0;
    dc_addr_in   = '0;
    dc_wdata_in  = '0;
    mem_resp_in  = 1'b0;
    mem_rdata_in = '0;
    tick();
    tick();
    chk_quiet("reset");
    chk("reset_addr", mem_addr_out, 32'h0);
    chk("reset_wdata", mem_wdata_out, '0);
    chk("reset_write", mem_write_out, 1'b0);
    reset = 1'b0;
    tick();

    // Spurious response while idle.
    mem_resp_in  = 1'b1;
    mem_rdata_in = LINE_C3;
    tick();
    mem_resp_in  = 1'b0;
    mem_rdata_in = '0;
    chk_quiet("spurious");
    chk("spurious_addr", mem_addr_out, 32'h0);

    // I-cache refill with a 4-cycle memory latency.
    ic_req_in  = 1'b1;
    ic_addr_in = 32'h100;
    serve("ic_refill", 1'b0, 32'h100, 1'b0, '0, LINE_AA, 3, lat);
    chk("ic_refill_issue_lat", lat, 1);
    ic_req_in = 1'b0;
    tick();
    chk_quiet("ic_refill_done");

    // D-cache write-back; wdata input is scrambled after issue.
    dc_req_in   = 1'b1;
    dc_write_in = 1'b1;
    dc_addr_in  = 32'h200;
    dc_wdata_in = LINE_55;
    serve("dc_wb", 1'b1, 32'h200, 1'b1, LINE_55, LINE_C3, 2, lat);
    dc_req_in   = 1'b0;
    dc_write_in = 1'b0;
    tick();
    chk_quiet("dc_wb_done");

    // Simultaneous requests released after service.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    first_dc = 1'b0;
`else
    first_dc = 1'b1;
`endif
    ic_req_in  = 1'b1;
    ic_addr_in = 32'h300;
    dc_req_in  = 1'b1;
    dc_addr_in = 32'h400;
    serve("both_1st", first_dc, first_dc ? 32'h400 : 32'h300, 1'b0, '0, LINE_17, 1, lat);
    if (first_dc) dc_req_in = 1'b0;
    else ic_req_in = 1'b0;
    serve("both_2nd", !first_dc, first_dc ? 32'h300 : 32'h400, 1'b0, '0, LINE_AA, 1, lat);
    chk("both_2nd_gap", lat, 2);
    ic_req_in = 1'b0;
    dc_req_in = 1'b0;
    tick();
    chk_quiet("both_done");

    // Reset while waiting on memory; the late response must be dropped.
    dc_req_in  = 1'b1;
    dc_addr_in = 32'h500;
    tick();
    chk("rst_issue", mem_req_out, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    dc_req_in = 1'b0;
    chk("rst_busy", busy_out, 1'b0);
    tick();
    mem_resp_in  = 1'b1;
    mem_rdata_in = LINE_55;
    tick();
    mem_resp_in  = 1'b0;
    mem_rdata_in = '0;
    chk_quiet("rst_late_resp");
    ic_req_in  = 1'b1;
    ic_addr_in = 32'h600;
    serve("rst_next", 1'b0, 32'h600, 1'b0, '0, LINE_C3, 1, lat);
    ic_req_in = 1'b0;
    tick();
    chk_quiet("rst_next_done");

    // Both held across four transactions from a fresh reset.
    do_reset();
    ic_req_in  = 1'b1;
    ic_addr_in = 32'h700;
    dc_req_in  = 1'b1;
    dc_addr_in = 32'h800;
    for (int k = 0; k < 4; k++) begin
      bit want_dc;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      want_dc = (k % 2) == 1;
`else
      want_dc = 1'b1;
`endif
      serve($sformatf("held_%0d", k), want_dc, want_dc ? 32'h800 : 32'h700, 1'b0, '0,
            {4{k[31:0] + 32'h0101_0101}}, 1, lat);
    end
    ic_req_in = 1'b0;
    dc_req_in = 1'b0;
    tick();
    chk_quiet("held_done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
